// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register index and hazard sequencer state.
package rv32i_types;

    // Architectural register index (x0..x31)
    typedef logic [4:0] rv32i_reg;

    // Hazard sequencer: running freely, or holding for outstanding cache responses
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    // Width of the performance counters
    localparam int unsigned PERF_CNT_W = 32;

    // True when a producer register matches a consumer operand that is really read.
    // x0 never creates a dependency because it is hard-wired to zero.
    function automatic logic reg_dep(input rv32i_reg prod, input rv32i_reg cons, input logic used);
        return used && (prod != 5'd0) && (prod == cons);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction in ID reads, so forwarding cannot supply the value in time.
module load_use_detect
    import rv32i_types::*;
(
    input  logic     id_ex_mem_read,
    input  rv32i_reg id_ex_rd,
    input  rv32i_reg if_id_rs1,
    input  rv32i_reg if_id_rs2,
    input  logic     if_id_uses_rs1,
    input  logic     if_id_uses_rs2,
    output logic     hazard
);

    logic w_dep_rs1;
    logic w_dep_rs2;

    assign w_dep_rs1 = reg_dep(id_ex_rd, if_id_rs1, if_id_uses_rs1);
    assign w_dep_rs2 = reg_dep(id_ex_rd, if_id_rs2, if_id_uses_rs2);

    // Only a load creates the hazard; ALU results are forwarded from EX/MEM
    assign hazard = id_ex_mem_read && (w_dep_rs1 || w_dep_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline. Freezes on cache misses,
// inserts a one-cycle bubble on load-use, flushes wrong-path work on taken
// branches, and counts stall cycles and flushes.
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_ex_mem_read,
    input  rv32i_reg    id_ex_rd,
    input  rv32i_reg    if_id_rs1,
    input  rv32i_reg    if_id_rs2,
    input  logic        if_id_uses_rs1,
    input  logic        if_id_uses_rs2,
    input  logic        br_taken,
    input  logic        imem_req,
    input  logic        dmem_req,
    input  logic        imem_resp,
    input  logic        dmem_resp,
    output logic        imem_req_gated,
    output logic        dmem_req_gated,
    output logic        pc_load,
    output logic        if_id_load,
    output logic        id_ex_load,
    output logic        ex_mem_load,
    output logic        mem_wb_load,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    hazard_state_t         r_state;
    logic                  r_i_done;
    logic                  r_d_done;
    logic [PERF_CNT_W-1:0] r_stall_cycles;
    logic [PERF_CNT_W-1:0] r_flush_count;

    logic w_hazard;
    logic w_i_ok;
    logic w_d_ok;
    logic w_freeze;
    logic w_do_flush;
    logic w_do_bubble;

    load_use_detect u_load_use_detect (
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .if_id_uses_rs1 (if_id_uses_rs1),
        .if_id_uses_rs2 (if_id_uses_rs2),
        .hazard         (w_hazard)
    );

    // A side is satisfied if it has nothing pending, completes now, or completed earlier in this wait
    assign w_i_ok      = !imem_req || imem_resp || r_i_done;
    assign w_d_ok      = !dmem_req || dmem_resp || r_d_done;
    assign w_freeze    = !(w_i_ok && w_d_ok);
    // A branch held in EX across a freeze is only acted on once the pipeline moves
    assign w_do_flush  = !w_freeze && br_taken;
    assign w_do_bubble = !w_freeze && !br_taken && w_hazard;

    // Sequencer FSM and per-side completion latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        r_state  <= MEM_WAIT;
                        r_i_done <= imem_resp;
                        r_d_done <= dmem_resp;
                    end
                end
                MEM_WAIT: begin
                    if (!w_freeze) begin
                        r_state  <= RUN;
                        r_i_done <= 1'b0;
                        r_d_done <= 1'b0;
                    end else begin
                        if (imem_resp) r_i_done <= 1'b1;
                        if (dmem_resp) r_d_done <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                end
            endcase
        end
    end

    // Performance counters; both wrap naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_freeze || w_do_bubble) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_do_flush)              r_flush_count  <= r_flush_count + 1'b1;
        end
    end

    // Enable/flush muxing: freeze > branch flush > load-use bubble > normal advance
    always_comb begin
        imem_req_gated = 1'b0;
        dmem_req_gated = 1'b0;
        pc_load        = 1'b0;
        if_id_load     = 1'b0;
        id_ex_load     = 1'b0;
        ex_mem_load    = 1'b0;
        mem_wb_load    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        if (!rst) begin
            // Completed requests are not re-issued while the other side is still waiting
            imem_req_gated = imem_req && !r_i_done;
            dmem_req_gated = dmem_req && !r_d_done;
            if (w_freeze) begin
                // everything holds
            end else if (w_do_flush) begin
                pc_load     = 1'b1;
                if_id_load  = 1'b1;
                id_ex_load  = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_do_bubble) begin
                // Hold PC and IF/ID, push a bubble into EX, let older work drain
                id_ex_load  = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
            end else begin
                pc_load     = 1'b1;
                if_id_load  = 1'b1;
                id_ex_load  = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: inputs change just after the falling
// edge, combinational outputs are checked mid-low-phase, counters after the
// following rising edge.
module tb_pipeline_ctrl;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_ex_mem_read;
    rv32i_reg    id_ex_rd;
    rv32i_reg    if_id_rs1;
    rv32i_reg    if_id_rs2;
    logic        if_id_uses_rs1;
    logic        if_id_uses_rs2;
    logic        br_taken;
    logic        imem_req;
    logic        dmem_req;
    logic        imem_resp;
    logic        dmem_resp;
    logic        imem_req_gated;
    logic        dmem_req_gated;
    logic        pc_load;
    logic        if_id_load;
    logic        id_ex_load;
    logic        ex_mem_load;
    logic        mem_wb_load;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .if_id_uses_rs1 (if_id_uses_rs1),
        .if_id_uses_rs2 (if_id_uses_rs2),
        .br_taken       (br_taken),
        .imem_req       (imem_req),
        .dmem_req       (dmem_req),
        .imem_resp      (imem_resp),
        .dmem_resp      (dmem_resp),
        .imem_req_gated (imem_req_gated),
        .dmem_req_gated (dmem_req_gated),
        .pc_load        (pc_load),
        .if_id_load     (if_id_load),
        .id_ex_load     (id_ex_load),
        .ex_mem_load    (ex_mem_load),
        .mem_wb_load    (mem_wb_load),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Packs {pc,if_id,id_ex,ex_mem,mem_wb,if_id_flush,id_ex_flush}
    function automatic logic [6:0] ctl();
        return {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush};
    endfunction

    localparam logic [6:0] CTL_ZERO   = 7'b00000_00;
    localparam logic [6:0] CTL_RUN    = 7'b11111_00;
    localparam logic [6:0] CTL_FLUSH  = 7'b11111_11;
    localparam logic [6:0] CTL_BUBBLE = 7'b00111_01;

    task automatic idle_inputs();
        id_ex_mem_read = 1'b0;
        id_ex_rd       = 5'd0;
        if_id_rs1      = 5'd0;
        if_id_rs2      = 5'd0;
        if_id_uses_rs1 = 1'b0;
        if_id_uses_rs2 = 1'b0;
        br_taken       = 1'b0;
        imem_req       = 1'b0;
        dmem_req       = 1'b0;
        imem_resp      = 1'b0;
        dmem_resp      = 1'b0;
    endtask

    // Advance to the next falling edge (passes one rising edge)
    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // ---- reset state ----
        @(negedge clk);
        #1;
        chk("rst_ctl", {25'd0, ctl()}, {25'd0, CTL_ZERO});
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_flush", flush_count, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ctl", {25'd0, ctl()}, {25'd0, CTL_RUN});

        // ---- load-use: rd=5 used as rs2 ----
        next_cyc();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_uses_rs2 = 1'b1;
        if_id_rs1 = 5'd3; if_id_uses_rs1 = 1'b1;
        #1;
        chk("lu_ctl", {25'd0, ctl()}, {25'd0, CTL_BUBBLE});
        next_cyc();
        idle_inputs();
        #1;
        chk("lu_stall", stall_cycles, 32'd1);
        chk("lu_after_ctl", {25'd0, ctl()}, {25'd0, CTL_RUN});
        // rs2 match but not actually used: no hazard
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_uses_rs2 = 1'b0;
        #1;
        chk("lu_unused_ctl", {25'd0, ctl()}, {25'd0, CTL_RUN});
        // rd = x0: never a hazard
        id_ex_rd = 5'd0; if_id_rs2 = 5'd0; if_id_uses_rs2 = 1'b1;
        #1;
        chk("lu_x0_ctl", {25'd0, ctl()}, {25'd0, CTL_RUN});
        next_cyc();
        idle_inputs();
        #1;
        chk("lu_x0_stall", stall_cycles, 32'd1);

        // ---- split miss after a fresh reset ----
        rst = 1'b1;
        #1;
        chk("rst2_stall", stall_cycles, 32'd0);
        next_cyc();
        rst = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            imem_req  = 1'b1;
            dmem_req  = 1'b1;
            imem_resp = (c == 2);
            dmem_resp = (c == 6);
            #1;
            chk($sformatf("split_c%0d_ctl", c), {25'd0, ctl()},
                {25'd0, (c <= 5) ? CTL_ZERO : CTL_RUN});
            chk($sformatf("split_c%0d_igate", c), {31'd0, imem_req_gated},
                {31'd0, (c >= 3) ? 1'b0 : 1'b1});
            chk($sformatf("split_c%0d_dgate", c), {31'd0, dmem_req_gated}, 32'd1);
            next_cyc();
        end
        idle_inputs();
        #1;
        chk("split_stall", stall_cycles, 32'd6);
        // Back in RUN with flags clear: a request answered in its first cycle passes straight through
        imem_req = 1'b1; imem_resp = 1'b1;
        #1;
        chk("same_cyc_ctl", {25'd0, ctl()}, {25'd0, CTL_RUN});
        chk("same_cyc_igate", {31'd0, imem_req_gated}, 32'd1);
        next_cyc();
        idle_inputs();
        #1;
        chk("same_cyc_stall", stall_cycles, 32'd6);

        // ---- branch during a data miss ----
        for (int c = 0; c <= 3; c++) begin
            br_taken  = 1'b1;
            dmem_req  = 1'b1;
            dmem_resp = (c == 3);
            #1;
            chk($sformatf("brmiss_c%0d_ctl", c), {25'd0, ctl()},
                {25'd0, (c < 3) ? CTL_ZERO : CTL_FLUSH});
            next_cyc();
        end
        idle_inputs();
        #1;
        chk("brmiss_flushcnt", flush_count, 32'd1);
        chk("brmiss_stall", stall_cycles, 32'd9);

        // ---- branch and load-use together: flush wins, no stall counted ----
        br_taken = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7; if_id_uses_rs1 = 1'b1;
        #1;
        chk("br_lu_ctl", {25'd0, ctl()}, {25'd0, CTL_FLUSH});
        next_cyc();
        idle_inputs();
        #1;
        chk("br_lu_stall", stall_cycles, 32'd9);
        chk("br_lu_flushcnt", flush_count, 32'd2);

        // ---- both responses in the same cycle end the wait without an extra cycle ----
        imem_req = 1'b1; dmem_req = 1'b1;
        #1;
        chk("dual_c0_ctl", {25'd0, ctl()}, {25'd0, CTL_ZERO});
        next_cyc();
        imem_resp = 1'b1; dmem_resp = 1'b1;
        #1;
        chk("dual_c1_ctl", {25'd0, ctl()}, {25'd0, CTL_RUN});
        next_cyc();
        idle_inputs();
        #1;
        chk("dual_stall", stall_cycles, 32'd10);

        // ---- reset in the middle of MEM_WAIT with d_done set ----
        imem_req = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1;
        next_cyc();
        dmem_resp = 1'b0;
        #1;
        chk("mw_dgate", {31'd0, dmem_req_gated}, 32'd0);
        chk("mw_igate", {31'd0, imem_req_gated}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mw_rst_igate", {31'd0, imem_req_gated}, 32'd0);
        chk("mw_rst_ctl", {25'd0, ctl()}, {25'd0, CTL_ZERO});
        chk("mw_rst_stall", stall_cycles, 32'd0);
        chk("mw_rst_flush", flush_count, 32'd0);
        next_cyc();
        rst = 1'b0;
        #1;
        // d_done cleared: the data request is issued again and the pipeline waits
        chk("mw_rel_dgate", {31'd0, dmem_req_gated}, 32'd1);
        chk("mw_rel_ctl", {25'd0, ctl()}, {25'd0, CTL_ZERO});
        next_cyc();
        imem_resp = 1'b1; dmem_resp = 1'b1;
        #1;
        chk("mw_rel_adv_ctl", {25'd0, ctl()}, {25'd0, CTL_RUN});
        next_cyc();
        idle_inputs();
        #1;
        chk("mw_rel_stall", stall_cycles, 32'd1);

        // ---- stall counter wrap ----
        force dut.r_stall_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cycles;
        #1;
        chk("wrap_pre", stall_cycles, 32'hFFFF_FFFF);
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd9; if_id_rs1 = 5'd9; if_id_uses_rs1 = 1'b1;
        next_cyc();
        idle_inputs();
        #1;
        chk("wrap_stall", stall_cycles, 32'd0);
        chk("wrap_flush", flush_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        fail_cnt++;
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
